// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between ALU results
// and load returns. Loads that lose arbitration wait in a 2-entry in-order
// buffer; a starvation counter eventually forces the buffer head onto the port.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_we,
    input  logic [ADDRESS_WIDTH-1:0] alu_ad,
    input  logic [DATA_WIDTH-1:0]    alu_wd,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDRESS_WIDTH-1:0] ld_ad,
    input  logic [DATA_WIDTH-1:0]    ld_wd,
    output logic                     alu_stall,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] ad3,
    output logic [DATA_WIDTH-1:0]    WD3,
    input  logic [ADDRESS_WIDTH-1:0] hz_ad,
    output logic                     hz_pending,
    output logic [1:0]               fifo_count
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

    // Entry 0 is always the head; entry 1 is only meaningful when two are held.
    logic [ADDRESS_WIDTH-1:0] ent_ad [2];
    logic [DATA_WIDTH-1:0]    ent_wd [2];
    logic [1:0]               count;
    logic [WW-1:0]            wait_cnt;

    logic                     alu_req;
    logic                     ld_acc;
    logic                     grant_head;
    logic                     grant_alu;
    logic                     grant_byp;
    logic                     grant_any;
    logic                     enq;
    logic                     enq_slot;
    logic [1:0]               count_nxt;
    logic [ADDRESS_WIDTH-1:0] sel_ad;
    logic [DATA_WIDTH-1:0]    sel_wd;

    assign fifo_count = count;
    assign ld_ready   = (count != 2'd2) && !rst;
    assign alu_stall  = !rst && (count != 2'd0) && (wait_cnt == WAIT_MAX);

    // Address 0 is the hardwired zero register, so such writes are no-ops.
    assign alu_req = alu_we && (alu_ad != '0);
    assign ld_acc  = ld_valid && ld_ready && (ld_ad != '0);

    // Arbitration: forced head, ALU, head, then bypass of an incoming load.
    always_comb begin
        grant_head = 1'b0;
        grant_alu  = 1'b0;
        grant_byp  = 1'b0;
        if (alu_stall) begin
            grant_head = 1'b1;
        end else if (alu_req) begin
            grant_alu = 1'b1;
        end else if (count != 2'd0) begin
            grant_head = 1'b1;
        end else if (ld_acc) begin
            grant_byp = 1'b1;
        end
        grant_any = grant_head || grant_alu || grant_byp;
        enq       = ld_acc && !grant_byp;
        // New entry lands behind whatever survives this cycle's dequeue.
        enq_slot  = (count == 2'd1) && !grant_head;
        count_nxt = count;
        if (enq && !grant_head) begin
            count_nxt = count + 2'd1;
        end else if (!enq && grant_head) begin
            count_nxt = count - 2'd1;
        end
        sel_ad = ent_ad[0];
        sel_wd = ent_wd[0];
        if (grant_alu) begin
            sel_ad = alu_ad;
            sel_wd = alu_wd;
        end else if (grant_byp) begin
            sel_ad = ld_ad;
            sel_wd = ld_wd;
        end
    end

    // Hazard lookup against buffered loads and the write currently on the port.
    always_comb begin
        hz_pending = 1'b0;
        if (hz_ad != '0) begin
            if ((count != 2'd0) && (ent_ad[0] == hz_ad)) hz_pending = 1'b1;
            if ((count == 2'd2) && (ent_ad[1] == hz_ad)) hz_pending = 1'b1;
            if (WE3 && (ad3 == hz_ad))                   hz_pending = 1'b1;
        end
    end

    // Control state and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            wait_cnt <= '0;
            WE3      <= 1'b0;
            ad3      <= '0;
            WD3      <= '0;
        end else begin
            count <= count_nxt;
            WE3   <= grant_any;
            if (grant_any) begin
                ad3 <= sel_ad;
                WD3 <= sel_wd;
            end
            if ((count == 2'd0) || grant_head) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    // Buffer payload; validity is tracked by count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (grant_head) begin
            ent_ad[0] <= ent_ad[1];
            ent_wd[0] <= ent_wd[1];
        end
        if (enq) begin
            ent_ad[enq_slot] <= ld_ad;
            ent_wd[enq_slot] <= ld_wd;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: ADDRESS_WIDTH, 5, register address width.
REQ-002 Parameter: DATA_WIDTH, 32, write data width.
REQ-003 Parameter: STARVE_LIMIT, 4, cycles a buffered load may wait before it forces the port.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 alu_we  in  1  ALU writeback request.
REQ-008 alu_ad  in  ADDRESS_WIDTH  ALU destination register.
REQ-009 alu_wd  in  DATA_WIDTH  ALU result.
REQ-010 ld_valid  in  1  load writeback offer.
REQ-011 ld_ready  out  1  load offer accepted this cycle if ld_valid also high.
REQ-012 ld_ad  in  ADDRESS_WIDTH  load destination register.
REQ-013 ld_wd  in  DATA_WIDTH  load data.
REQ-014 alu_stall  out  1  ALU request ignored this cycle; upstream SHALL hold it.
REQ-015 WE3  out  1  registered register-file write enable.
REQ-016 ad3  out  ADDRESS_WIDTH  registered write address.
REQ-017 WD3  out  DATA_WIDTH  registered write data.
REQ-018 hz_ad  in  ADDRESS_WIDTH  hazard query address.
REQ-019 hz_pending  out  1  a write to hz_ad is buffered or on the port.
REQ-020 fifo_count  out  2  number of buffered loads (0..2).

Function
REQ-021 Register-file write port is shared by ALU and load; WE3/ad3/WD3 SHALL be flops, so a granted write appears one cycle after its grant cycle.
REQ-022 A request with address 0 SHALL count as no request: alu_we with alu_ad==0 frees the slot; a load with ld_ad==0 completes its handshake and is dropped.
REQ-023 Load buffer: 2-entry in-order FIFO of {ad, wd}; ld_ready = (fifo_count<2) and not rst; no same-cycle full pass-through.
REQ-024 Grant priority per cycle: (1) FIFO head if alu_stall; (2) valid ALU request; (3) FIFO head; (4) incoming accepted load (bypass) only if FIFO empty and no ALU request; otherwise the accepted load is enqueued.
REQ-025 A bypassed load SHALL NOT enter the FIFO; minimum load latency is 1 cycle.
REQ-026 Simultaneous dequeue and enqueue SHALL leave fifo_count unchanged, with the new entry behind the remaining entries.
REQ-027 wait_cnt counts cycles with a non-empty FIFO and no head grant, saturating at STARVE_LIMIT; clears on any head grant or when empty.
REQ-028 alu_stall = (wait_cnt==STARVE_LIMIT) and (fifo_count!=0), decoded from registered state; when high, head is granted regardless of alu_we.
REQ-029 No grant in a cycle SHALL produce WE3=0 next cycle; ad3/WD3 SHALL then hold previous values.
REQ-030 hz_pending = (hz_ad!=0) and (hz_ad matches any valid FIFO entry or (WE3 and ad3==hz_ad)); combinational.
REQ-031 Writes to the same address SHALL reach the port in acceptance order for loads; ALU writes never reorder with each other.

Reset
REQ-032 While rst is high at a clock edge: FIFO emptied, fifo_count=0, wait_cnt=0, WE3=0, ad3=0, WD3=0.
REQ-033 During rst, ld_ready=0 and alu_stall=0; requests presented in reset cycles SHALL be discarded.
REQ-034 Reset mid-operation SHALL discard buffered loads without issuing them.

Verification
REQ-035 Idle FIFO, alu_we=1 alu_ad=3 alu_wd=0xAA -> next cycle WE3=1 ad3=3 WD3=0xAA.
REQ-036 alu_we=0, ld_valid=1 ld_ad=7 ld_wd=0x55 -> ld_ready=1, next cycle WE3=1 ad3=7 WD3=0x55, fifo_count stays 0.
REQ-037 alu_we=1 (ad 4) plus loads to 5 and 6 in consecutive cycles -> fifo_count reaches 2, ld_ready=0; after alu_we drops, 5 then 6 written on consecutive cycles.
REQ-038 FIFO holds one load, alu_we=1 continuously (nonzero ad) -> after 4 waiting cycles alu_stall=1 for exactly one cycle and the load is written the next cycle; wait_cnt clears.
REQ-039 alu_we=1 alu_ad=0 and ld_valid=1 ld_ad=0 -> no write issued, fifo_count unchanged, ld_ready=1.
REQ-040 FIFO holds load to 9, hz_ad=9 -> hz_pending=1; hz_ad=0 -> 0; assert rst one cycle -> fifo_count=0, WE3=0, hz_pending=0.
